branch_predictor: RTL and testbench

Gshare conditional-branch predictor for the five-stage MIPS pipeline. Predicts direction in Decode from a table of 2-bit saturating counters indexed by PC XOR global history. Carries each prediction through Execute to Memory, where the resolved outcome updates the table and history. Produces `pred_wrongM`, which the hazard unit consumes to flush D/E/M.

---
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor.sv | 110 +++++++++++
 tb/tb_branch_predictor.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Pipeline-side connection of the gshare branch predictor.
// master: the pipeline/hazard side. It drives the Decode PC and branch flag,
//         the stall/flush controls and the resolved Memory outcome.
// slave:  the predictor. It returns the Decode prediction, the Memory
//         mispredict flag, the global history and the retirement statistics.
interface branch_predictor_if #(
    parameter int unsigned GHR_W = 8,
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      pcD;
    logic             branchD;
    logic             stallD;
    logic             flushE;
    logic             flushM;
    logic             actual_takenM;
    logic             pred_takeD;
    logic             pred_wrongM;
    logic [GHR_W-1:0] ghr;
    logic [CNT_W-1:0] br_cntM;
    logic [CNT_W-1:0] miss_cntM;

    modport master (
        output pcD, branchD, stallD, flushE, flushM, actual_takenM,
        input  pred_takeD, pred_wrongM, ghr, br_cntM, miss_cntM
    );

    modport slave (
        input  pcD, branchD, stallD, flushE, flushM, actual_takenM,
        output pred_takeD, pred_wrongM, ghr, br_cntM, miss_cntM
    );
endinterface

// File: rtl/branch_predictor.sv
// Gshare conditional-branch predictor for a five-stage pipeline.
// The direction is predicted in Decode from 2-bit saturating counters indexed
// by PC XOR global history. The prediction rides through Execute to Memory,
// where the resolved outcome trains the table and shifts the history.
// Ports: clk, resetn (async, active low), bp (branch_predictor_if.slave).
//   in : pcD, branchD, stallD, flushE, flushM, actual_takenM
//   out: pred_takeD, pred_wrongM (both combinational), ghr, br_cntM, miss_cntM
module branch_predictor #(
    parameter int unsigned GHR_W = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    branch_predictor_if.slave   bp
);
    localparam int unsigned PHT_N = 1 << GHR_W;

    logic [1:0]       pht [PHT_N];
    logic [GHR_W-1:0] ghr_q;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    logic             valid_e;
    logic             pred_e;
    logic [GHR_W-1:0] idx_e;
    logic             valid_m;
    logic             pred_m;
    logic [GHR_W-1:0] idx_m;

    logic [GHR_W-1:0] idx_d;
    logic             pred_d;
    logic             wrong_m;
    logic [1:0]       cnt_m;

    // Only the word-index bits of the PC hash into the table. stallD needs no
    // action here: the hazard unit pairs it with flushE, so a stalled branch
    // enters Execute only once.
    logic unused_ok;
    assign unused_ok = ^{bp.pcD[31:GHR_W+2], bp.pcD[1:0], bp.stallD};

    // Decode-stage lookup; a same-cycle Memory write is not bypassed.
    assign idx_d = bp.pcD[GHR_W+1:2] ^ ghr_q;
    assign pred_d = bp.branchD & pht[idx_d][1];

    assign cnt_m = pht[idx_m];
    assign wrong_m = valid_m & (pred_m != bp.actual_takenM);

    assign bp.pred_takeD = pred_d;
    assign bp.pred_wrongM = wrong_m;
    assign bp.ghr = ghr_q;
    assign bp.br_cntM = br_cnt_q;
    assign bp.miss_cntM = miss_cnt_q;

    // D->E and E->M prediction carriers; flushes kill wrong-path branches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_e <= 1'b0;
            pred_e <= 1'b0;
            idx_e <= '0;
            valid_m <= 1'b0;
            pred_m <= 1'b0;
            idx_m <= '0;
        end else begin
            if (bp.flushE) begin
                valid_e <= 1'b0;
                pred_e <= 1'b0;
                idx_e <= '0;
            end else begin
                valid_e <= bp.branchD;
                pred_e <= pred_d;
                idx_e <= idx_d;
            end
            if (bp.flushM) begin
                valid_m <= 1'b0;
                pred_m <= 1'b0;
                idx_m <= '0;
            end else begin
                valid_m <= valid_e;
                pred_m <= pred_e;
                idx_m <= idx_e;
            end
        end
    end

    // Non-speculative training at resolution. flushM only clears the next
    // M contents, so the branch currently in M still retires this edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(PHT_N); i++) begin
                pht[i] <= 2'b01;
            end
            ghr_q <= '0;
            br_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else if (valid_m) begin
            if (bp.actual_takenM) begin
                if (cnt_m != 2'b11) begin
                    pht[idx_m] <= cnt_m + 2'd1;
                end
            end else begin
                if (cnt_m != 2'b00) begin
                    pht[idx_m] <= cnt_m - 2'd1;
                end
            end
            ghr_q <= {ghr_q[GHR_W-2:0], bp.actual_takenM};
            br_cnt_q <= br_cnt_q + CNT_W'(1);
            miss_cnt_q <= miss_cnt_q + CNT_W'(wrong_m);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor. Each row drives one cycle of
// pipeline inputs and carries the hand-derived outputs for that cycle. The
// expected record is queued when the row is driven and popped when the
// outputs are sampled on the falling edge.
module tb_branch_predictor;
    localparam int unsigned GHR_W = 8;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned N_VEC = 40;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    branch_predictor_if #(.GHR_W(GHR_W), .CNT_W(CNT_W)) bp ();

    branch_predictor #(.GHR_W(GHR_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .resetn(resetn),
        .bp(bp)
    );

    typedef struct {
        logic [31:0] pc;
        logic        br;
        logic        st;
        logic        fe;
        logic        fm;
        logic        act;
        logic        rst;
        logic        pred;
        logic        wrong;
        logic [7:0]  ghr;
        logic [31:0] brc;
        logic [31:0] miss;
    } vec_t;

    typedef struct {
        logic        pred;
        logic        wrong;
        logic [7:0]  ghr;
        logic [31:0] brc;
        logic [31:0] miss;
    } exp_t;

    vec_t tbl [N_VEC];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   row = -1;

    function automatic vec_t mk(input logic [31:0] pc, input logic br, input logic st,
                                input logic fe, input logic fm, input logic act,
                                input logic rst, input logic pred, input logic wrong,
                                input logic [7:0] g, input int brc, input int miss);
        vec_t v;
        v.pc = pc; v.br = br; v.st = st; v.fe = fe; v.fm = fm; v.act = act; v.rst = rst;
        v.pred = pred; v.wrong = wrong; v.ghr = g;
        v.brc = 32'(brc); v.miss = 32'(miss);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, got, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("pred_takeD", 32'(bp.pred_takeD), 32'(e.pred));
        chk("pred_wrongM", 32'(bp.pred_wrongM), 32'(e.wrong));
        chk("ghr", 32'(bp.ghr), 32'(e.ghr));
        chk("br_cntM", bp.br_cntM, e.brc);
        chk("miss_cntM", bp.miss_cntM, e.miss);
    endtask

    initial begin
        //            pc     br st fe fm act rst | pred wr  ghr   br miss
        // training at PHT index 0x10, pc compensates for the moving history
        tbl[0]  = mk(32'h40, 1, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 0);
        tbl[1]  = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 0, 8'h00, 0, 0);
        tbl[2]  = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 1, 8'h00, 0, 0);
        tbl[3]  = mk(32'h44, 1, 0, 0, 0, 1, 0,   1, 0, 8'h01, 1, 1);
        tbl[4]  = mk(32'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h01, 1, 1);
        tbl[5]  = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 0, 8'h01, 1, 1);
        tbl[6]  = mk(32'h4C, 1, 0, 0, 0, 0, 0,   1, 0, 8'h03, 2, 1);
        tbl[7]  = mk(32'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h03, 2, 1);
        tbl[8]  = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 0, 8'h03, 2, 1);
        tbl[9]  = mk(32'h5C, 1, 0, 0, 0, 0, 0,   1, 0, 8'h07, 3, 1);
        tbl[10] = mk(32'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h07, 3, 1);
        tbl[11] = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 0, 8'h07, 3, 1);
        // saturated at 11; a not-taken outcome mispredicts and steps to 10
        tbl[12] = mk(32'h7C, 1, 0, 0, 0, 0, 0,   1, 0, 8'h0F, 4, 1);
        tbl[13] = mk(32'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h0F, 4, 1);
        tbl[14] = mk(32'h00, 0, 0, 0, 0, 0, 0,   0, 1, 8'h0F, 4, 1);
        // mispredict in M with flushE/flushM: the following branch is killed
        tbl[15] = mk(32'h00, 1, 0, 0, 0, 0, 0,   0, 0, 8'h1E, 5, 2);
        tbl[16] = mk(32'h04, 1, 0, 0, 0, 0, 0,   0, 0, 8'h1E, 5, 2);
        tbl[17] = mk(32'h00, 0, 0, 1, 1, 1, 0,   0, 1, 8'h1E, 5, 2);
        tbl[18] = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 0, 8'h3D, 6, 3);
        tbl[19] = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 0, 8'h3D, 6, 3);
        // wrong-path kill: index 0x1F still at 01 proves the killed branch never trained
        tbl[20] = mk(32'h88, 1, 0, 1, 0, 1, 0,   0, 0, 8'h3D, 6, 3);
        tbl[21] = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 0, 8'h3D, 6, 3);
        tbl[22] = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 0, 8'h3D, 6, 3);
        // stall held two cycles with flushE, then release: one update only
        tbl[23] = mk(32'h88, 1, 1, 1, 0, 1, 0,   0, 0, 8'h3D, 6, 3);
        tbl[24] = mk(32'h88, 1, 1, 1, 0, 1, 0,   0, 0, 8'h3D, 6, 3);
        tbl[25] = mk(32'h88, 1, 0, 0, 0, 1, 0,   0, 0, 8'h3D, 6, 3);
        tbl[26] = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 0, 8'h3D, 6, 3);
        tbl[27] = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 1, 8'h3D, 6, 3);
        tbl[28] = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 0, 8'h7B, 7, 4);
        tbl[29] = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 0, 8'h7B, 7, 4);
        // reset mid-stream with branches in flight: no stale update afterwards
        tbl[30] = mk(32'h00, 1, 0, 0, 0, 0, 0,   0, 0, 8'h7B, 7, 4);
        tbl[31] = mk(32'h00, 1, 0, 0, 0, 0, 0,   0, 0, 8'h7B, 7, 4);
        tbl[32] = mk(32'h40, 1, 0, 0, 0, 1, 1,   0, 0, 8'h00, 0, 0);
        // collision: M writes index 0x10 while D reads it, D sees the old value
        tbl[33] = mk(32'h40, 1, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 0);
        tbl[34] = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 0, 8'h00, 0, 0);
        tbl[35] = mk(32'h40, 1, 0, 0, 0, 1, 0,   0, 1, 8'h00, 0, 0);
        tbl[36] = mk(32'h44, 1, 0, 0, 0, 0, 0,   1, 0, 8'h01, 1, 1);
        tbl[37] = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 1, 8'h01, 1, 1);
        tbl[38] = mk(32'h00, 0, 0, 0, 0, 1, 0,   0, 0, 8'h03, 2, 2);
        tbl[39] = mk(32'h00, 0, 0, 0, 0, 0, 0,   0, 0, 8'h07, 3, 2);

        // reset held with a branch in Decode and a taken outcome presented
        resetn = 1'b0;
        bp.pcD = 32'h40;
        bp.branchD = 1'b1;
        bp.stallD = 1'b0;
        bp.flushE = 1'b0;
        bp.flushM = 1'b0;
        bp.actual_takenM = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all('{pred: 1'b0, wrong: 1'b0, ghr: 8'h00, brc: 32'd0, miss: 32'd0});

        for (int i = 0; i < int'(N_VEC); i++) begin
            @(posedge clk);
            #1;
            row = i;
            resetn = ~tbl[i].rst;
            bp.pcD = tbl[i].pc;
            bp.branchD = tbl[i].br;
            bp.stallD = tbl[i].st;
            bp.flushE = tbl[i].fe;
            bp.flushM = tbl[i].fm;
            bp.actual_takenM = tbl[i].act;
            sb.push_back('{pred: tbl[i].pred, wrong: tbl[i].wrong, ghr: tbl[i].ghr,
                           brc: tbl[i].brc, miss: tbl[i].miss});
            @(negedge clk);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard row %0d: got empty queue expected one record", i);
            end else begin
                chk_all(sb.pop_front());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
